// File: rtl/adc_sample_sequencer_if.sv
// Avalon-MM slave bus bundle for the ADC sample sequencer.
interface adc_sample_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/adc_sample_sequencer.sv
// Serial ADC conversion sequencer with periodic/one-shot start, sample FIFO and
// level interrupt, controlled over an Avalon-MM register slave.
module adc_sample_sequencer #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned LEAD_BITS  = 3,
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IRQ_THRESH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    adc_sample_sequencer_if.slave        bus,
    output logic                         irq,
    output logic                         adc_cs_n,
    output logic                         adc_sclk,
    input  logic                         adc_miso
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned NBITS = LEAD_BITS + DATA_W;
    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RECOVER} state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;

    logic                ctrl_en;
    logic                ctrl_irq_en;
    logic [15:0]         period;
    logic [15:0]         per_cnt;
    logic                overrun;
    logic                missed;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;

    logic wr_en, rd_en, ctrl_wr, period_wr, oneshot, clear;
    logic tick, start_req, busy, in_conv, abort, div_last;
    logic push, full, pop, do_push;
    logic [31:0] status_word;
    logic [31:0] data_word;
    logic unused_wdata;

    // Bus decode and control strobes
    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign rd_en     = bus.chipselect & ~bus.read_n;
    assign ctrl_wr   = wr_en & (bus.address == 2'd0);
    assign period_wr = wr_en & (bus.address == 2'd1);
    assign oneshot   = ctrl_wr & bus.writedata[1];
    assign clear     = ctrl_wr & bus.writedata[2];
    assign unused_wdata = ^bus.writedata[31:16];

    assign tick      = ctrl_en & (per_cnt == period);
    assign start_req = tick | oneshot;
    assign busy      = (state != IDLE);
    assign in_conv   = (state == SETUP) | (state == SHIFT) | (state == HOLD);
    assign abort     = ctrl_wr & ~bus.writedata[0] & ctrl_en & in_conv;
    assign div_last  = (div_cnt == DIV_W'(SCLK_DIV - 1));

    assign push    = (state == HOLD) & div_last & ~abort;
    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = rd_en & (bus.address == 2'd3) & (level != '0);
    assign do_push = push & (clear | ~full | pop);

    // Conversion FSM driving the ADC pins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (abort) begin
            state    <= RECOVER;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            div_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        state    <= SETUP;
                        adc_cs_n <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        adc_sclk <= ~adc_sclk;
                        if (!adc_sclk) begin
                            // Rising edge: lead bits are clocked but not kept
                            if (bit_cnt >= BIT_W'(LEAD_BITS))
                                shreg <= {shreg[DATA_W-2:0], adc_miso};
                        end else if (bit_cnt == BIT_W'(NBITS - 1)) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        state    <= RECOVER;
                        adc_cs_n <= 1'b1;
                        div_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                RECOVER: begin
                    if (div_last) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                end
            endcase
        end
    end

    // Control/period registers and the periodic tick counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            period      <= 16'hFFFF;
            per_cnt     <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en     <= bus.writedata[0];
                ctrl_irq_en <= bus.writedata[3];
            end
            if (period_wr)
                period <= bus.writedata[15:0];
            if (!ctrl_en || period_wr || tick)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + 16'd1;
        end
    end

    // Sticky flags; a new miss wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun <= 1'b0;
            missed  <= 1'b0;
        end else begin
            if (clear)
                overrun <= 1'b0;
            else if (push && full && !pop)
                overrun <= 1'b1;
            if (start_req && busy)
                missed <= 1'b1;
            else if (clear)
                missed <= 1'b0;
        end
    end

    // FIFO pointers and level; clear re-bases the read pointer so a same-cycle push survives
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                level  <= LW'(1);
            end else begin
                level  <= '0;
            end
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= shreg;
    end

    always_comb begin
        status_word             = '0;
        status_word[LW-1:0]     = level;
        status_word[8]          = busy;
        status_word[9]          = overrun;
        status_word[10]         = missed;
        data_word               = '0;
        if (level != '0) begin
            data_word[31]           = 1'b1;
            data_word[DATA_W-1:0]   = mem[rd_ptr];
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (rd_en) begin
                case (bus.address)
                    2'd0:    bus.readdata <= {28'd0, ctrl_irq_en, 2'b00, ctrl_en};
                    2'd1:    bus.readdata <= {16'd0, period};
                    2'd2:    bus.readdata <= status_word;
                    default: bus.readdata <= data_word;
                endcase
            end
            irq <= ctrl_irq_en & ((level >= LW'(IRQ_THRESH)) | overrun);
        end
    end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer: bus reads queue expected words, a monitor
// compares readdata one cycle later; a behavioural ADC shifts a 15-bit word MSB first.
module tb_adc_sample_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic irq, adc_cs_n, adc_sclk, adc_miso;

    adc_sample_sequencer_if bus ();

    adc_sample_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .irq      (irq),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .adc_miso (adc_miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_d = 1'b0;

    // ADC model: data changes after each sclk fall, word latched at CS fall
    logic [14:0] word = '0;
    logic [14:0] cur = '0;
    bit          auto_inc = 1'b0;
    int          sclk_falls = 0, cs_snap = 0;
    int          fall_cnt = 0, rise_cnt = 0, fall_base = 0, rise_base = 0;
    longint      fall_t [32];

    function automatic logic miso_bit(logic [14:0] w, int k);
        if (k < 0 || k > 14) return 1'b0;
        return w[14-k];
    endfunction

    assign adc_miso = miso_bit(cur, sclk_falls - cs_snap);

    always @(negedge adc_sclk) sclk_falls++;
    always @(posedge adc_cs_n) rise_cnt++;
    always @(negedge adc_cs_n) begin
        cur = word + (auto_inc ? 15'(fall_cnt - fall_base) : 15'd0);
        cs_snap = sclk_falls;
        fall_t[fall_cnt % 32] = $time;
        fall_cnt++;
    end

    always @(posedge clk) rd_d <= bus.chipselect & ~bus.read_n;

    initial begin : monitor
        logic [31:0] e;
        string n;
        forever begin
            @(negedge clk);
            if (rd_d) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_read got=%h want=none", bus.readdata);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (bus.readdata !== e) begin
                        bad++;
                        $display("FAIL %s got=%h want=%h", n, bus.readdata, e);
                    end
                end
            end
        end
    end

    task automatic chk(string n, longint got, longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(logic [1:0] a, logic [31:0] want, string n);
        exp_q.push_back(want);
        name_q.push_back(n);
        bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
    endtask

    task automatic wait_rises(int n, int lim);
        int c = 0;
        while ((rise_cnt - rise_base) < n && c < lim) begin cyc(1); c++; end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lowcnt, pulses, first_irq, c;
        logic prev;
        bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0;
        bus.read_n = 1'b1; bus.write_n = 1'b1;

        // Reset values
        cyc(3);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 0);
        reset_n = 1'b1;
        cyc(1);
        rd(2'd0, 32'h0000_0000, "rst_control");
        rd(2'd1, 32'h0000_FFFF, "rst_period");
        rd(2'd2, 32'h0000_0000, "rst_status");
        rd(2'd3, 32'h0000_0000, "rst_data_empty");
        chk("rst_irq", irq, 0);

        // One-shot conversion: frame shape and data
        word = 15'h0A5A; auto_inc = 1'b0;
        wr(2'd0, 32'h2);
        lowcnt = 0; pulses = 0; prev = adc_sclk;
        while (adc_cs_n == 1'b0 && lowcnt < 400) begin
            lowcnt++;
            if (adc_sclk && !prev) pulses++;
            prev = adc_sclk;
            cyc(1);
        end
        chk("os_cs_low_cycles", lowcnt, 128);
        chk("os_sclk_pulses", pulses, 15);
        cyc(6);
        rd(2'd2, 32'h0000_0001, "os_level1");
        rd(2'd3, 32'h8000_0A5A, "os_data_a5a");
        rd(2'd2, 32'h0000_0000, "os_level0");
        word = 15'h05A5;
        wr(2'd0, 32'h2);
        c = 0;
        while (adc_cs_n == 1'b0 && c < 300) begin cyc(1); c++; end
        cyc(6);
        rd(2'd3, 32'h8000_05A5, "os_data_5a5");

        // Periodic fill to overrun with irq at threshold
        fall_base = fall_cnt; rise_base = rise_cnt;
        word = 15'h0100; auto_inc = 1'b1;
        wr(2'd1, 32'd199);
        wr(2'd0, 32'h9);
        first_irq = -1; c = 0;
        while ((rise_cnt - rise_base) < 17 && c < 3900) begin
            if (irq && first_irq < 0) first_irq = rise_cnt - rise_base;
            cyc(1); c++;
        end
        wr(2'd0, 32'h8);
        chk("per_samples", rise_cnt - rise_base, 17);
        chk("per_irq_first_sample", first_irq, 8);
        cyc(6);
        chk("per_irq_high", irq, 1);
        rd(2'd2, 32'h0000_0210, "per_status_full_ovr");
        rd(2'd3, 32'h8000_0100, "per_first_sample");
        rd(2'd2, 32'h0000_020F, "per_status_after_pop");
        wr(2'd0, 32'hC);
        cyc(2);
        chk("clr_irq_low", irq, 0);
        rd(2'd2, 32'h0000_0000, "clr_status");

        // Period shorter than a conversion: missed ticks, 150-cycle spacing
        fall_base = fall_cnt; rise_base = rise_cnt;
        word = 15'h0300;
        wr(2'd1, 32'd49);
        wr(2'd0, 32'h1);
        wait_rises(3, 1000);
        wr(2'd0, 32'h0);
        chk("miss_conversions", rise_cnt - rise_base, 3);
        chk("miss_spacing_1", fall_t[(fall_base + 1) % 32] - fall_t[fall_base % 32], 1500);
        chk("miss_spacing_2", fall_t[(fall_base + 2) % 32] - fall_t[(fall_base + 1) % 32], 1500);
        cyc(6);
        rd(2'd2, 32'h0000_0403, "miss_status");
        wr(2'd0, 32'h4);
        cyc(1);
        rd(2'd2, 32'h0000_0000, "miss_clr_status");

        // EN cleared 60 cycles into SHIFT aborts the frame
        auto_inc = 1'b0; word = 15'h0777;
        wr(2'd1, 32'd999);
        wr(2'd0, 32'h1);
        c = 0;
        while (adc_cs_n == 1'b1 && c < 1200) begin cyc(1); c++; end
        cyc(63);
        wr(2'd0, 32'h0);
        chk("abort_cs_n", adc_cs_n, 1);
        chk("abort_sclk", adc_sclk, 0);
        cyc(6);
        rd(2'd2, 32'h0000_0000, "abort_status");
        word = 15'h0123;
        wr(2'd0, 32'h2);
        c = 0;
        while (adc_cs_n == 1'b0 && c < 300) begin cyc(1); c++; end
        cyc(6);
        rd(2'd3, 32'h8000_0123, "abort_next_oneshot");

        // Full FIFO: pop on push cycle, then clear on push cycle
        fall_base = fall_cnt; rise_base = rise_cnt;
        word = 15'h0200; auto_inc = 1'b1;
        wr(2'd1, 32'd139);
        wr(2'd0, 32'h1);
        wait_rises(16, 2700);
        wr(2'd0, 32'h0);
        cyc(6);
        rd(2'd2, 32'h0000_0010, "full_status");
        wr(2'd0, 32'h2);
        cyc(127);
        rd(2'd3, 32'h8000_0200, "full_pop_on_push");
        cyc(8);
        rd(2'd2, 32'h0000_0010, "full_no_overrun");
        wr(2'd0, 32'h2);
        cyc(127);
        wr(2'd0, 32'h4);
        cyc(8);
        rd(2'd2, 32'h0000_0001, "clr_on_push_level");
        rd(2'd3, 32'h8000_0211, "clr_on_push_data");

        // Reset in the middle of a frame
        wr(2'd0, 32'h2);
        cyc(50);
        reset_n = 1'b0;
        cyc(1);
        chk("midrst_cs_n", adc_cs_n, 1);
        chk("midrst_sclk", adc_sclk, 0);
        reset_n = 1'b1;
        cyc(1);
        rd(2'd1, 32'h0000_FFFF, "midrst_period");
        rd(2'd2, 32'h0000_0000, "midrst_status");

        cyc(3);
        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
